// File: rtl/chdr_mgmt_hop_router.sv
`default_nettype none
// ============================================================================
//  Module   : chdr_mgmt_hop_router
//  Brief    : Steers whole CHDR management packets to the return port, one of
//             NUM_PORTS forward hop ports, or a drop sink (zero latency).
//  Revision : 1.0
// ============================================================================
module chdr_mgmt_hop_router #(
    parameter int CHDR_W    = 64,
    parameter int NUM_PORTS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHDR_W-1:0]           s_axis_chdr_tdata,
    input  logic [9:0]                  s_axis_chdr_tdest,
    input  logic                        s_axis_chdr_tid,
    input  logic                        s_axis_chdr_tlast,
    input  logic                        s_axis_chdr_tvalid,
    output logic                        s_axis_chdr_tready,
    output logic [CHDR_W-1:0]           m_axis_ret_tdata,
    output logic                        m_axis_ret_tlast,
    output logic                        m_axis_ret_tvalid,
    input  logic                        m_axis_ret_tready,
    output logic [NUM_PORTS*CHDR_W-1:0] m_axis_fwd_tdata,
    output logic [NUM_PORTS-1:0]        m_axis_fwd_tlast,
    output logic [NUM_PORTS-1:0]        m_axis_fwd_tvalid,
    input  logic [NUM_PORTS-1:0]        m_axis_fwd_tready,
    output logic                        drop_stb,
    output logic [31:0]                 drop_count
);

    typedef enum logic [1:0] {
        ST_HEAD = 2'd0,
        ST_RET  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RT_RET  = 2'd0,
        RT_FWD  = 2'd1,
        RT_DROP = 2'd2
    } route_t;

    localparam logic [10:0] c_num_ports = 11'(NUM_PORTS);

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_sel_port;
    logic [9:0]  w_sel_next;
    route_t      w_route;
    logic [9:0]  w_port;
    logic        w_fwd_ready;
    logic        w_ready;
    logic        w_accept;
    logic        w_drop_done;
    logic        r_drop_stb;
    logic [31:0] r_drop_count;

    always_comb begin
        w_route      = RT_DROP;
        w_port       = r_sel_port;
        w_fwd_ready  = 1'b0;
        w_ready      = 1'b1;
        w_accept     = 1'b0;
        w_drop_done  = 1'b0;
        w_state_next = r_state;
        w_sel_next   = r_sel_port;

        // Header beats are routed from their own sideband; later beats reuse the latch
        case (r_state)
            ST_HEAD: begin
                if (s_axis_chdr_tid) begin
                    w_route = RT_RET;
                end else if ({1'b0, s_axis_chdr_tdest} < c_num_ports) begin
                    w_route = RT_FWD;
                    w_port  = s_axis_chdr_tdest;
                end
            end
            ST_RET:  w_route = RT_RET;
            ST_FWD:  w_route = RT_FWD;
            default: w_route = RT_DROP;
        endcase

        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_port == 10'(i)) begin
                w_fwd_ready = m_axis_fwd_tready[i];
            end
        end

        case (w_route)
            RT_RET:  w_ready = m_axis_ret_tready;
            RT_FWD:  w_ready = w_fwd_ready;
            default: w_ready = 1'b1;
        endcase

        w_accept    = s_axis_chdr_tvalid & w_ready;
        w_drop_done = w_accept & s_axis_chdr_tlast & (w_route == RT_DROP);

        if (w_accept) begin
            if (r_state == ST_HEAD) begin
                if (!s_axis_chdr_tlast) begin
                    case (w_route)
                        RT_RET: w_state_next = ST_RET;
                        RT_FWD: begin
                            w_state_next = ST_FWD;
                            w_sel_next   = s_axis_chdr_tdest;
                        end
                        default: w_state_next = ST_DROP;
                    endcase
                end
            end else if (s_axis_chdr_tlast) begin
                w_state_next = ST_HEAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HEAD;
            r_sel_port   <= 10'd0;
            r_drop_stb   <= 1'b0;
            r_drop_count <= 32'd0;
        end else begin
            r_state    <= w_state_next;
            r_sel_port <= w_sel_next;
            r_drop_stb <= w_drop_done;
            if (w_drop_done && (r_drop_count != 32'hFFFF_FFFF)) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end
    end

    assign s_axis_chdr_tready = w_ready;
    assign m_axis_ret_tdata   = s_axis_chdr_tdata;
    assign m_axis_ret_tlast   = s_axis_chdr_tlast;
    assign m_axis_ret_tvalid  = s_axis_chdr_tvalid & (w_route == RT_RET);
    assign drop_stb           = r_drop_stb;
    assign drop_count         = r_drop_count;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fwd
            assign m_axis_fwd_tdata[gi*CHDR_W +: CHDR_W] = s_axis_chdr_tdata;
            assign m_axis_fwd_tlast[gi]  = s_axis_chdr_tlast;
            assign m_axis_fwd_tvalid[gi] = s_axis_chdr_tvalid & (w_route == RT_FWD) &
                                           (w_port == 10'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_chdr_mgmt_hop_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_chdr_mgmt_hop_router
//  Brief    : Directed self-checking bench for chdr_mgmt_hop_router.
//  Revision : 1.0
// ============================================================================
module tb_chdr_mgmt_hop_router;

    localparam int CHDR_W    = 64;
    localparam int NUM_PORTS = 4;

    logic                        clk;
    logic                        rst;
    logic [CHDR_W-1:0]           s_tdata;
    logic [9:0]                  s_tdest;
    logic                        s_tid;
    logic                        s_tlast;
    logic                        s_tvalid;
    logic                        s_tready;
    logic [CHDR_W-1:0]           ret_tdata;
    logic                        ret_tlast;
    logic                        ret_tvalid;
    logic                        ret_tready;
    logic [NUM_PORTS*CHDR_W-1:0] fwd_tdata;
    logic [NUM_PORTS-1:0]        fwd_tlast;
    logic [NUM_PORTS-1:0]        fwd_tvalid;
    logic [NUM_PORTS-1:0]        fwd_tready;
    logic                        drop_stb;
    logic [31:0]                 drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    chdr_mgmt_hop_router #(
        .CHDR_W    (CHDR_W),
        .NUM_PORTS (NUM_PORTS)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_chdr_tdata  (s_tdata),
        .s_axis_chdr_tdest  (s_tdest),
        .s_axis_chdr_tid    (s_tid),
        .s_axis_chdr_tlast  (s_tlast),
        .s_axis_chdr_tvalid (s_tvalid),
        .s_axis_chdr_tready (s_tready),
        .m_axis_ret_tdata   (ret_tdata),
        .m_axis_ret_tlast   (ret_tlast),
        .m_axis_ret_tvalid  (ret_tvalid),
        .m_axis_ret_tready  (ret_tready),
        .m_axis_fwd_tdata   (fwd_tdata),
        .m_axis_fwd_tlast   (fwd_tlast),
        .m_axis_fwd_tvalid  (fwd_tvalid),
        .m_axis_fwd_tready  (fwd_tready),
        .drop_stb           (drop_stb),
        .drop_count         (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one beat shortly after a rising edge, checks routing mid-cycle,
    // then returns just after the edge that accepts it.
    task automatic beat(input string tag, input logic [63:0] data, input logic [9:0] dest,
                        input logic tid, input logic last, input logic exp_ret,
                        input logic [3:0] exp_fwd);
        s_tdata  = data;
        s_tdest  = dest;
        s_tid    = tid;
        s_tlast  = last;
        s_tvalid = 1'b1;
        @(negedge clk);
        check({tag, " ret_v"}, 64'(ret_tvalid), 64'(exp_ret));
        check({tag, " fwd_v"}, 64'(fwd_tvalid), 64'(exp_fwd));
        check({tag, " rdy"},   64'(s_tready),   64'd1);
        if (exp_ret) begin
            check({tag, " ret_d"}, ret_tdata, data);
            check({tag, " ret_l"}, 64'(ret_tlast), 64'(last));
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (exp_fwd[k]) begin
                check({tag, " fwd_d"}, fwd_tdata[k*CHDR_W +: CHDR_W], data);
                check({tag, " fwd_l"}, 64'(fwd_tlast[k]), 64'(last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int cyc;
        logic pat;
        rst        = 1'b1;
        s_tdata    = '0;
        s_tdest    = '0;
        s_tid      = 1'b0;
        s_tlast    = 1'b0;
        s_tvalid   = 1'b0;
        ret_tready = 1'b1;
        fwd_tready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst drop_count", 64'(drop_count), 64'd0);
        check("rst drop_stb",   64'(drop_stb),   64'd0);
        check("rst fwd_v",      64'(fwd_tvalid), 64'd0);
        check("rst ret_v",      64'(ret_tvalid), 64'd0);

        // Forward basic: 3 words to port 2
        beat("fwd b0", 64'hA000_0000_0000_0001, 10'd2, 1'b0, 1'b0, 1'b0, 4'b0100);
        beat("fwd b1", 64'hA000_0000_0000_0002, 10'd2, 1'b0, 1'b0, 1'b0, 4'b0100);
        beat("fwd b2", 64'hA000_0000_0000_0003, 10'd2, 1'b0, 1'b1, 1'b0, 4'b0100);
        check("fwd drop_count", 64'(drop_count), 64'd0);

        // Return: 2 words, tdest ignored
        beat("ret b0", 64'hB000_0000_0000_0001, 10'h3FF, 1'b1, 1'b0, 1'b1, 4'b0000);
        check("ret stb0", 64'(drop_stb), 64'd0);
        beat("ret b1", 64'hB000_0000_0000_0002, 10'h3FF, 1'b1, 1'b1, 1'b1, 4'b0000);
        check("ret stb1", 64'(drop_stb), 64'd0);

        // Drop: 4 words to nonexistent port 9
        beat("drop b0", 64'hC000_0000_0000_0001, 10'd9, 1'b0, 1'b0, 1'b0, 4'b0000);
        beat("drop b1", 64'hC000_0000_0000_0002, 10'd9, 1'b0, 1'b0, 1'b0, 4'b0000);
        beat("drop b2", 64'hC000_0000_0000_0003, 10'd9, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("drop mid stb", 64'(drop_stb), 64'd0);
        beat("drop b3", 64'hC000_0000_0000_0004, 10'd9, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("drop stb",   64'(drop_stb),   64'd1);
        check("drop count", 64'(drop_count), 64'd1);
        idle();
        check("drop stb off", 64'(drop_stb), 64'd0);
        beat("drop1 b0", 64'hC100_0000_0000_0001, 10'd9, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("drop1 stb",   64'(drop_stb),   64'd1);
        check("drop1 count", 64'(drop_count), 64'd2);

        // Header latching: later beats carry different sideband
        beat("latch b0", 64'hD000_0000_0000_0001, 10'd1, 1'b0, 1'b0, 1'b0, 4'b0010);
        check("latch stb", 64'(drop_stb), 64'd0);
        beat("latch b1", 64'hD000_0000_0000_0002, 10'd3, 1'b1, 1'b0, 1'b0, 4'b0010);
        beat("latch b2", 64'hD000_0000_0000_0003, 10'd3, 1'b1, 1'b1, 1'b0, 4'b0010);

        // Backpressure: port 0 ready pattern 1,0,0,1,0,0,...
        acc = 0;
        cyc = 0;
        s_tdest = 10'd0;
        s_tid   = 1'b0;
        while (acc < 5 && cyc < 40) begin
            pat          = ((cyc % 3) == 0);
            fwd_tready   = {3'b111, pat};
            s_tdata      = 64'hE000_0000_0000_0000 | 64'(acc);
            s_tlast      = (acc == 4);
            s_tvalid     = 1'b1;
            @(negedge clk);
            check("bp fwd_v", 64'(fwd_tvalid), 64'b0001);
            check("bp rdy",   64'(s_tready),   64'(pat));
            check("bp data",  fwd_tdata[0 +: CHDR_W], 64'hE000_0000_0000_0000 | 64'(acc));
            @(posedge clk);
            #1;
            if (pat) acc++;
            cyc++;
        end
        check("bp beats", 64'(acc), 64'd5);
        check("bp cycles", 64'(cyc), 64'd13);
        fwd_tready = 4'hF;

        // Back-to-back single-word packets
        beat("b2b p3",  64'hF000_0000_0000_0003, 10'd3, 1'b0, 1'b1, 1'b0, 4'b1000);
        beat("b2b ret", 64'hF000_0000_0000_0010, 10'd2, 1'b1, 1'b1, 1'b1, 4'b0000);
        beat("b2b p0",  64'hF000_0000_0000_0000, 10'd0, 1'b0, 1'b1, 1'b0, 4'b0001);

        // Reset mid-packet
        beat("rp b0", 64'h1000_0000_0000_0001, 10'd1, 1'b0, 1'b0, 1'b0, 4'b0010);
        beat("rp b1", 64'h1000_0000_0000_0002, 10'd1, 1'b0, 1'b0, 1'b0, 4'b0010);
        s_tvalid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rp count", 64'(drop_count), 64'd0);
        check("rp stb",   64'(drop_stb),   64'd0);
        beat("rp hdr ret", 64'h2000_0000_0000_0001, 10'd1, 1'b1, 1'b1, 1'b1, 4'b0000);
        beat("rp hdr p2",  64'h2000_0000_0000_0002, 10'd2, 1'b0, 1'b1, 1'b0, 4'b0100);

        // Boundary: tdest == NUM_PORTS drops
        beat("edge drop", 64'h3000_0000_0000_0001, 10'd4, 1'b0, 1'b1, 1'b0, 4'b0000);
        check("edge count", 64'(drop_count), 64'd1);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
